// File: rtl/mccoy_pkg.sv
// mccoy_pkg -- shared definitions for the McCoy instruction feeder.
//
// Holds the sequencer state encoding, default sizing for program memory and
// instruction width, and the NOP value driven when no instruction is live.
package mccoy_pkg;

  // Sequencer states; encoding is visible on the feeder's state port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } feeder_state_e;

  localparam int IW_DEFAULT    = 6;
  localparam int DEPTH_DEFAULT = 16;

  // Instruction presented whenever instr_valid is low.
  localparam logic [IW_DEFAULT-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/mccoy_prog_mem.sv
// mccoy_prog_mem -- DEPTH x IW program memory, one write port, one
// asynchronous read port. Contents are not reset.
//
// Ports:
//   clk      in   clock; writes land on the rising edge
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address
//   rdata    out  combinational read data
module mccoy_prog_mem
  import mccoy_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int IW    = IW_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  // Single write port; no reset so the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read so the sequencer can fetch the next instruction in
  // the same cycle it decides the next pc.
  assign rdata = mem[raddr];

endmodule

// File: rtl/mccoy_instr_feeder.sv
// mccoy_instr_feeder -- loads a small program and streams it to the McCoy
// core one instruction per cycle, with redirect (jump) support.
//
// Ports:
//   clk          in   sole clock
//   reset        in   synchronous active-high reset
//   clear        in   empty the program (IDLE/HALT only)
//   load_en      in   append load_data to the program (IDLE only)
//   load_data    in   instruction to append
//   run          in   level request to execute; low returns to IDLE
//   jump_valid   in   redirect request
//   jump_addr    in   redirect target
//   instr        out  current instruction, NOP when not valid
//   instr_valid  out  instr is a live program instruction
//   pc           out  address of instr
//   prog_len     out  number of stored instructions
//   state        out  IDLE=0, RUN=1, HALT=2
//   load_err     out  sticky: write to full memory or outside IDLE
//
// Build option: define MCCOY_FEEDER_LOOP_EN to make the end of the program
// wrap back to entry 0 instead of halting.
module mccoy_instr_feeder
  import mccoy_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int IW    = IW_DEFAULT,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load_en,
  input  logic [IW-1:0] load_data,
  input  logic          run,
  input  logic          jump_valid,
  input  logic [AW-1:0] jump_addr,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic [LW-1:0] prog_len,
  output logic [1:0]    state,
  output logic          load_err
);

  feeder_state_e state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [LW-1:0] prog_len_q, prog_len_d;
  logic          load_err_q, load_err_d;

  logic          mem_we;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;
  logic          at_last;
  logic          jump_oob;

  mccoy_prog_mem #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_len_q[AW-1:0]),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // pc sits on the final stored entry, and a jump target beyond the program.
  assign at_last  = (({1'b0, pc_q} + LW'(1)) == prog_len_q);
  assign jump_oob = ({1'b0, jump_addr} >= prog_len_q);

  // Next-state logic. The read address is steered to whatever pc will be
  // next so the fetched word is registered alongside it, giving one
  // instruction per cycle with no bubble.
  always_comb begin
    state_d       = state_q;
    instr_d       = IW'(NOP_INSTR);
    instr_valid_d = 1'b0;
    pc_d          = pc_q;
    prog_len_d    = prog_len_q;
    load_err_d    = load_err_q;
    mem_we        = 1'b0;
    rd_addr       = pc_q;

    case (state_q)
      ST_IDLE: begin
        if (run && (prog_len_q != '0)) begin
          state_d       = ST_RUN;
          pc_d          = '0;
          rd_addr       = '0;
          instr_d       = rd_data;
          instr_valid_d = 1'b1;
        end else if (clear) begin
          prog_len_d = '0;
          load_err_d = 1'b0;
        end else if (load_en) begin
          if (prog_len_q == LW'(DEPTH)) begin
            load_err_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + LW'(1);
          end
        end
      end

      ST_RUN: begin
        if (load_en) begin
          load_err_d = 1'b1;
        end
        if (!run) begin
          state_d = ST_IDLE;
        end else if (jump_valid) begin
          if (jump_oob) begin
            state_d = ST_HALT;
          end else begin
            pc_d          = jump_addr;
            rd_addr       = jump_addr;
            instr_d       = rd_data;
            instr_valid_d = 1'b1;
          end
        end else if (at_last) begin
`ifdef MCCOY_FEEDER_LOOP_EN
          pc_d          = '0;
          rd_addr       = '0;
          instr_d       = rd_data;
          instr_valid_d = 1'b1;
`else
          state_d = ST_HALT;
`endif
        end else begin
          pc_d          = pc_q + AW'(1);
          rd_addr       = pc_q + AW'(1);
          instr_d       = rd_data;
          instr_valid_d = 1'b1;
        end
      end

      ST_HALT: begin
        // clear takes precedence over a stray write in the same cycle
        if (clear) begin
          prog_len_d = '0;
          load_err_d = 1'b0;
        end else if (load_en) begin
          load_err_d = 1'b1;
        end
        if (!run) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All outputs come straight from these registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      instr_q       <= IW'(NOP_INSTR);
      instr_valid_q <= 1'b0;
      pc_q          <= '0;
      prog_len_q    <= '0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_q          <= pc_d;
      prog_len_q    <= prog_len_d;
      load_err_q    <= load_err_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign prog_len    = prog_len_q;
  assign state       = state_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_mccoy_instr_feeder.sv
// tb_mccoy_instr_feeder -- directed self-checking bench for the feeder with
// default sizing (DEPTH=16, IW=6). Expectations for the end-of-program
// behaviour follow MCCOY_FEEDER_LOOP_EN if it is defined for the build.
module tb_mccoy_instr_feeder;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       load_en;
  logic [5:0] load_data;
  logic       run;
  logic       jump_valid;
  logic [3:0] jump_addr;
  logic [5:0] instr;
  logic       instr_valid;
  logic [3:0] pc;
  logic [4:0] prog_len;
  logic [1:0] state;
  logic       load_err;

  int testCount = 0;
  int failCount = 0;

  mccoy_instr_feeder #(
    .DEPTH (16),
    .IW    (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .load_en     (load_en),
    .load_data   (load_data),
    .run         (run),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .prog_len    (prog_len),
    .state       (state),
    .load_err    (load_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's worth of inputs, then settle 1 ns past the edge so
  // outputs are sampled well away from the next active edge.
  task automatic applyStimulus(input logic c, input logic le,
                               input logic [5:0] ld, input logic r,
                               input logic jv, input logic [3:0] ja);
    clear      = c;
    load_en    = le;
    load_data  = ld;
    run        = r;
    jump_valid = jv;
    jump_addr  = ja;
    @(posedge clk);
    #1;
  endtask

  task automatic checkFeed(input string tag, input logic [1:0] st,
                           input logic v, input logic [5:0] ins,
                           input logic [3:0] p);
    checkOutput({tag, ".state"}, 32'(state), 32'(st));
    checkOutput({tag, ".valid"}, 32'(instr_valid), 32'(v));
    checkOutput({tag, ".instr"}, 32'(instr), 32'(ins));
    checkOutput({tag, ".pc"}, 32'(pc), 32'(p));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;

    // reset values
    checkFeed("rst", 2'd0, 1'b0, 6'h00, 4'd0);
    checkOutput("rst.len", 32'(prog_len), 32'd0);
    checkOutput("rst.err", 32'(load_err), 32'd0);

    // three-entry program, straight-line execution
    applyStimulus(1'b0, 1'b1, 6'b011001, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 6'b010110, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 6'b100001, 1'b0, 1'b0, 4'd0);
    checkOutput("ld3.len", 32'(prog_len), 32'd3);
    checkOutput("ld3.err", 32'(load_err), 32'd0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    checkFeed("seq0", 2'd1, 1'b1, 6'b011001, 4'd0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    checkFeed("seq1", 2'd1, 1'b1, 6'b010110, 4'd1);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    checkFeed("seq2", 2'd1, 1'b1, 6'b100001, 4'd2);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
`ifdef MCCOY_FEEDER_LOOP_EN
    checkFeed("wrap0", 2'd1, 1'b1, 6'b011001, 4'd0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    checkFeed("wrap1", 2'd1, 1'b1, 6'b010110, 4'd1);
`else
    checkFeed("end", 2'd2, 1'b0, 6'h00, 4'd2);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    checkFeed("halt", 2'd2, 1'b0, 6'h00, 4'd2);
`endif
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    checkOutput("stop.state", 32'(state), 32'd0);

    // run dropped mid-program, then restart from entry 0
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    checkFeed("pre", 2'd1, 1'b1, 6'b010110, 4'd1);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    checkFeed("drop", 2'd0, 1'b0, 6'h00, 4'd1);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    checkFeed("restart", 2'd1, 1'b1, 6'b011001, 4'd0);

    // write during RUN is dropped and flagged; reset mid-run stops issue
    applyStimulus(1'b0, 1'b1, 6'h3F, 1'b1, 1'b0, 4'd0);
    checkFeed("runld", 2'd1, 1'b1, 6'b010110, 4'd1);
    checkOutput("runld.err", 32'(load_err), 32'd1);
    checkOutput("runld.len", 32'(prog_len), 32'd3);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    checkFeed("pc2", 2'd1, 1'b1, 6'b100001, 4'd2);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    reset = 1'b0;
    checkFeed("midrst", 2'd0, 1'b0, 6'h00, 4'd0);
    checkOutput("midrst.len", 32'(prog_len), 32'd0);
    checkOutput("midrst.err", 32'(load_err), 32'd0);

    // empty program: run must not leave IDLE
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    checkFeed("empty", 2'd0, 1'b0, 6'h00, 4'd0);

    // four-entry program with jumps
    applyStimulus(1'b0, 1'b1, 6'h05, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 6'h0A, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 6'h14, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 6'h28, 1'b0, 1'b0, 4'd0);
    checkOutput("ld4.len", 32'(prog_len), 32'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    end
    checkFeed("j.pc3", 2'd1, 1'b1, 6'h28, 4'd3);
    // jump at end-of-program wins over halt/wrap
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 4'd0);
    checkFeed("j.to0", 2'd1, 1'b1, 6'h05, 4'd0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 4'd2);
    checkFeed("j.to2", 2'd1, 1'b1, 6'h14, 4'd2);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 4'd9);
    checkOutput("j.oob.state", 32'(state), 32'd2);
    checkOutput("j.oob.valid", 32'(instr_valid), 32'd0);
    checkOutput("j.oob.instr", 32'(instr), 32'd0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    checkOutput("j.idle", 32'(state), 32'd0);

    // fill memory, overflow write, verify last entry, then clear
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    checkOutput("clr.len", 32'(prog_len), 32'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 6'(i * 3 + 1), 1'b0, 1'b0, 4'd0);
    end
    checkOutput("full.len", 32'(prog_len), 32'd16);
    checkOutput("full.err", 32'(load_err), 32'd0);
    applyStimulus(1'b0, 1'b1, 6'h3F, 1'b0, 1'b0, 4'd0);
    checkOutput("ovf.len", 32'(prog_len), 32'd16);
    checkOutput("ovf.err", 32'(load_err), 32'd1);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 4'd0);
    checkFeed("full.pc0", 2'd1, 1'b1, 6'h01, 4'd0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 4'd15);
    checkFeed("full.pc15", 2'd1, 1'b1, 6'd46, 4'd15);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    checkOutput("full.idle", 32'(state), 32'd0);
    checkOutput("full.errkeep", 32'(load_err), 32'd1);
    // clear and load in the same cycle: clear wins
    applyStimulus(1'b1, 1'b1, 6'h2A, 1'b0, 1'b0, 4'd0);
    checkOutput("clr2.len", 32'(prog_len), 32'd0);
    checkOutput("clr2.err", 32'(load_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
